// File: rtl/toaplan2_audio_mixer_pkg.sv
// Shared types and constants for the Toaplan 2 audio mixer: FSM states,
// 4.4 gain format and the accumulator sizing rule.
package toaplan2_audio_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SAT,
    OUT
  } mix_state_t;

  localparam int GAIN_W    = 8;
  localparam int GAIN_FRAC = 4;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 8'h10;

  // Product is WIN+GAIN_W+1 bits; one extra bit per doubling of channels plus a spare.
  function automatic int acc_width(input int win, input int nch);
    return win + GAIN_W + 1 + $clog2(nch) + 1;
  endfunction

endpackage

// File: rtl/toaplan2_audio_mixer_if.sv
// Channel inputs and mixed outputs of the audio mixer, bundled for the top-level port.
interface toaplan2_audio_mixer_if
  import toaplan2_audio_mixer_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int WIN  = 16,
  parameter int WOUT = 16
);

  logic                   CEN;
  logic [NCH*WIN-1:0]     CH_IN;
  logic [NCH*GAIN_W-1:0]  CH_GAIN;
  logic [NCH-1:0]         CH_EN;
  logic [NCH*2-1:0]       CH_PAN;
  logic signed [WOUT-1:0] LEFT;
  logic signed [WOUT-1:0] RIGHT;
  logic                   SAMPLE;
  logic                   PEAK;
  logic                   BUSY;

  modport master (
    output CEN, CH_IN, CH_GAIN, CH_EN, CH_PAN,
    input  LEFT, RIGHT, SAMPLE, PEAK, BUSY
  );

  modport slave (
    input  CEN, CH_IN, CH_GAIN, CH_EN, CH_PAN,
    output LEFT, RIGHT, SAMPLE, PEAK, BUSY
  );

endinterface

// File: rtl/toaplan2_gain_ramp.sv
// One channel's current gain, stepping one LSB toward its target on each ramp pulse.
module toaplan2_gain_ramp
  import toaplan2_audio_mixer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic [GAIN_W-1:0] target,
  output logic [GAIN_W-1:0] cur_gain
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_gain <= '0;
    end else if (step) begin
      if (cur_gain < target) begin
        cur_gain <= cur_gain + 1'b1;
      end else if (cur_gain > target) begin
        cur_gain <= cur_gain - 1'b1;
      end
    end
  end

endmodule

// File: rtl/toaplan2_audio_mixer.sv
// Multi-channel stereo mixer: per-channel ramped gain, pan routing, one channel
// accumulated per cycle, then shift/saturate and a held clip indicator.
module toaplan2_audio_mixer
  import toaplan2_audio_mixer_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int WIN       = 16,
  parameter int WOUT      = 16,
  parameter int RAMP_DIV  = 256,
  parameter int PEAK_HOLD = 1024
)(
  input logic CLK96,
  input logic RESET96_N,
  toaplan2_audio_mixer_if.slave mix
);

  localparam int ACC_W = acc_width(WIN, NCH);
  localparam int PRD_W = WIN + GAIN_W + 1;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int PK_W  = $clog2(PEAK_HOLD + 1);

  logic [DIV_W-1:0]  div_cnt;
  logic              ramp_step;
  logic [GAIN_W-1:0] cur_gain [NCH];

  assign ramp_step = (div_cnt == DIV_W'(RAMP_DIV - 1));

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      div_cnt <= '0;
    end else if (ramp_step) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [GAIN_W-1:0] target;
    assign target = mix.CH_EN[i] ? mix.CH_GAIN[i*GAIN_W +: GAIN_W] : '0;

    toaplan2_gain_ramp u_ramp (
      .clk      (CLK96),
      .rst_n    (RESET96_N),
      .step     (ramp_step),
      .target   (target),
      .cur_gain (cur_gain[i])
    );
  end

  mix_state_t             state;
  logic [IDX_W-1:0]       idx;
  logic signed [WIN-1:0]  in_q   [NCH];
  logic [GAIN_W-1:0]      gain_q [NCH];
  logic [1:0]             pan_q  [NCH];
  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic signed [PRD_W-1:0] in_ext, gain_ext, prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic [WOUT:0]          sat_l_n, sat_r_n;
  logic [WOUT-1:0]        sat_l, sat_r;
  logic                   clip;
  logic [PK_W-1:0]        peak_cnt;
  logic signed [WOUT-1:0] left_q, right_q;
  logic                   sample_q, peak_q, busy_q;

  // Returns {clip, value}: the gain's fractional bits are dropped, then clamped to WOUT.
  function automatic logic [WOUT:0] saturate(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    logic [ACC_W-WOUT:0]     hi;
    sh = a >>> GAIN_FRAC;
    hi = sh[ACC_W-1:WOUT-1];
    if (hi == '0 || hi == '1) begin
      return {1'b0, sh[WOUT-1:0]};
    end else if (sh[ACC_W-1]) begin
      return {2'b11, {(WOUT-1){1'b0}}};
    end else begin
      return {2'b10, {(WOUT-1){1'b1}}};
    end
  endfunction

  always_comb begin
    in_ext   = PRD_W'(in_q[idx]);
    gain_ext = PRD_W'($signed({1'b0, gain_q[idx]}));
    prod     = in_ext * gain_ext;
    prod_ext = ACC_W'(prod);
    sat_l_n  = saturate(acc_l);
    sat_r_n  = saturate(acc_r);
  end

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state    <= IDLE;
      idx      <= '0;
      acc_l    <= '0;
      acc_r    <= '0;
      sat_l    <= '0;
      sat_r    <= '0;
      clip     <= 1'b0;
      peak_cnt <= '0;
      left_q   <= '0;
      right_q  <= '0;
      sample_q <= 1'b0;
      peak_q   <= 1'b0;
      busy_q   <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        in_q[i]   <= '0;
        gain_q[i] <= '0;
        pan_q[i]  <= '0;
      end
    end else begin
      sample_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mix.CEN) begin
            // Gains are captured with the samples so a ramp step mid-mix waits for the next mix.
            for (int unsigned i = 0; i < NCH; i++) begin
              in_q[i]   <= mix.CH_IN[i*WIN +: WIN];
              gain_q[i] <= cur_gain[i];
              pan_q[i]  <= mix.CH_PAN[i*2 +: 2];
            end
            acc_l  <= '0;
            acc_r  <= '0;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= ACC;
          end
        end
        ACC: begin
          if (pan_q[idx][0]) acc_l <= acc_l + prod_ext;
          if (pan_q[idx][1]) acc_r <= acc_r + prod_ext;
          if (idx == IDX_W'(NCH - 1)) begin
            state <= SAT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SAT: begin
          sat_l <= sat_l_n[WOUT-1:0];
          sat_r <= sat_r_n[WOUT-1:0];
          clip  <= sat_l_n[WOUT] | sat_r_n[WOUT];
          state <= OUT;
        end
        OUT: begin
          left_q   <= sat_l;
          right_q  <= sat_r;
          sample_q <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
          if (clip) begin
            peak_cnt <= PK_W'(PEAK_HOLD);
            peak_q   <= 1'b1;
          end else if (peak_cnt != '0) begin
            peak_cnt <= peak_cnt - 1'b1;
            if (peak_cnt == PK_W'(1)) peak_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mix.LEFT   = left_q;
  assign mix.RIGHT  = right_q;
  assign mix.SAMPLE = sample_q;
  assign mix.PEAK   = peak_q;
  assign mix.BUSY   = busy_q;

endmodule

// File: tb/tb_toaplan2_audio_mixer.sv
// Scoreboard bench for toaplan2_audio_mixer: expected L/R queued per accepted mix,
// popped on SAMPLE; scenario tasks check latency, ramp, peak hold and reset.
module tb_toaplan2_audio_mixer;
  import toaplan2_audio_mixer_pkg::*;

  localparam int NCH       = 4;
  localparam int WIN       = 16;
  localparam int WOUT      = 16;
  localparam int RAMP_DIV  = 4;
  localparam int PEAK_HOLD = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  toaplan2_audio_mixer_if #(.NCH(NCH), .WIN(WIN), .WOUT(WOUT)) bus ();

  toaplan2_audio_mixer #(
    .NCH(NCH), .WIN(WIN), .WOUT(WOUT), .RAMP_DIV(RAMP_DIV), .PEAK_HOLD(PEAK_HOLD)
  ) dut (
    .CLK96     (clk),
    .RESET96_N (rst_n),
    .mix       (bus)
  );

  int checks   = 0;
  int failures = 0;
  int samples  = 0;
  logic [31:0] exp_q [$];

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  function automatic logic [31:0] model(input logic [NCH*WIN-1:0] in, input logic [NCH*8-1:0] g,
                                        input logic [NCH-1:0] en, input logic [NCH*2-1:0] pan);
    longint sl, sr, p;
    logic [WIN-1:0] s;
    logic [1:0] pp;
    sl = 0;
    sr = 0;
    for (int i = 0; i < NCH; i++) begin
      s  = in[i*WIN +: WIN];
      pp = pan[i*2 +: 2];
      p  = longint'($signed(s)) * (en[i] ? longint'(g[i*8 +: 8]) : longint'(0));
      if (pp[0]) sl += p;
      if (pp[1]) sr += p;
    end
    sl = sl >>> 4;
    sr = sr >>> 4;
    return {sat16(sl), sat16(sr)};
  endfunction

  always @(negedge clk) begin
    if (bus.SAMPLE === 1'b1) begin
      logic [31:0] e;
      samples++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_sample got L=%h R=%h required no sample", bus.LEFT, bus.RIGHT);
      end else begin
        e = exp_q.pop_front();
        if ({bus.LEFT, bus.RIGHT} !== e) begin
          failures++;
          $display("FAIL scoreboard got L=%h R=%h required L=%h R=%h", bus.LEFT, bus.RIGHT, e[31:16], e[15:0]);
        end
      end
    end
  end

  task automatic do_mix(input bit push, input logic [31:0] e, output int lat, output int busy_n);
    if (push) exp_q.push_back(e);
    bus.CEN = 1'b1;
    @(posedge clk); #1;
    bus.CEN = 1'b0;
    lat    = 0;
    busy_n = (bus.BUSY === 1'b1) ? 1 : 0;
    while (bus.SAMPLE !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.BUSY === 1'b1) busy_n++;
    end
    @(negedge clk); #1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.LEFT !== 16'h0) begin failures++; $display("FAIL reset_left got=%h required=0000", bus.LEFT); end
    checks++; if (bus.RIGHT !== 16'h0) begin failures++; $display("FAIL reset_right got=%h required=0000", bus.RIGHT); end
    checks++; if (bus.SAMPLE !== 1'b0) begin failures++; $display("FAIL reset_sample got=%b required=0", bus.SAMPLE); end
    checks++; if (bus.PEAK !== 1'b0) begin failures++; $display("FAIL reset_peak got=%b required=0", bus.PEAK); end
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", bus.BUSY); end
    checks++; if (dut.cur_gain[0] !== 8'h00) begin failures++; $display("FAIL reset_gain got=%h required=00", dut.cur_gain[0]); end
  endtask

  task automatic test_ramp();
    int n;
    logic [7:0] g, gmin, gmax;
    bus.CH_GAIN = 32'h0000_0010;
    bus.CH_EN   = 4'hF;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (63) @(posedge clk);
    #1;
    checks++; if (dut.cur_gain[0] !== 8'h0F) begin failures++; $display("FAIL ramp_63 got=%h required=0f", dut.cur_gain[0]); end
    @(posedge clk); #1;
    checks++; if (dut.cur_gain[0] !== 8'h10) begin failures++; $display("FAIL ramp_64 got=%h required=10", dut.cur_gain[0]); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (dut.cur_gain[0] !== 8'h10) begin failures++; $display("FAIL ramp_hold got=%h required=10", dut.cur_gain[0]); end

    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (dut.cur_gain[0] !== 8'h0C && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    bus.CH_GAIN = 32'h0000_0008;
    gmin = 8'hFF;
    gmax = 8'h00;
    g    = 8'h00;
    repeat (60) begin
      @(posedge clk); #1;
      g = dut.cur_gain[0];
      if (g < gmin) gmin = g;
      if (g > gmax) gmax = g;
    end
    checks++; if (g !== 8'h08) begin failures++; $display("FAIL redirect_final got=%h required=08", g); end
    checks++; if (gmin !== 8'h08) begin failures++; $display("FAIL redirect_min got=%h required=08", gmin); end
    checks++; if (gmax !== 8'h0C) begin failures++; $display("FAIL redirect_max got=%h required=0c", gmax); end
  endtask

  task automatic test_unity();
    int lat, busy_n;
    bus.CH_GAIN = {4{GAIN_UNITY}};
    bus.CH_EN   = 4'hF;
    bus.CH_IN   = 64'h0000_0000_0800_1000;
    bus.CH_PAN  = 8'b01_01_01_01;
    settle(100);
    do_mix(1'b1, 32'h1800_0000, lat, busy_n);
    checks++; if (lat != 6) begin failures++; $display("FAIL unity_latency got=%0d required=6", lat); end
    checks++; if (busy_n != 6) begin failures++; $display("FAIL unity_busy_cycles got=%0d required=6", busy_n); end
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL unity_busy_after got=%b required=0", bus.BUSY); end
  endtask

  task automatic test_patterns();
    logic [63:0] ins  [3];
    logic [7:0]  pans [3];
    int lat, busy_n;
    ins[0] = 64'h0400_FC00_1000_0100; pans[0] = 8'b11_10_01_11;
    ins[1] = 64'h7FFF_7FFF_0000_0000; pans[1] = 8'b01_01_00_00;
    ins[2] = 64'h8000_8000_8000_8000; pans[2] = 8'b10_10_10_10;
    bus.CH_GAIN = 32'h2018_1008;
    settle(150);
    for (int k = 0; k < 3; k++) begin
      bus.CH_IN  = ins[k];
      bus.CH_PAN = pans[k];
      do_mix(1'b1, model(bus.CH_IN, bus.CH_GAIN, bus.CH_EN, bus.CH_PAN), lat, busy_n);
      checks++; if (lat != 6) begin failures++; $display("FAIL pattern%0d_latency got=%0d required=6", k, lat); end
    end
  endtask

  task automatic test_clip();
    int lat, busy_n;
    bus.CH_GAIN = {4{8'h20}};
    bus.CH_PAN  = 8'hFF;
    settle(100);
    bus.CH_IN = {4{16'h7FFF}};
    do_mix(1'b1, 32'h7FFF_7FFF, lat, busy_n);
    checks++; if (bus.PEAK !== 1'b1) begin failures++; $display("FAIL clip_pos_peak got=%b required=1", bus.PEAK); end
    bus.CH_IN = '0;
    for (int k = 1; k <= PEAK_HOLD; k++) begin
      do_mix(1'b1, 32'h0, lat, busy_n);
      checks++;
      if (bus.PEAK !== ((k < PEAK_HOLD) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL peak_hold_%0d got=%b required=%b", k, bus.PEAK, (k < PEAK_HOLD));
      end
    end
    bus.CH_IN = {4{16'h8000}};
    do_mix(1'b1, 32'h8000_8000, lat, busy_n);
    checks++; if (bus.PEAK !== 1'b1) begin failures++; $display("FAIL clip_neg_peak got=%b required=1", bus.PEAK); end
    bus.CH_IN = '0;
    repeat (PEAK_HOLD) do_mix(1'b1, 32'h0, lat, busy_n);
  endtask

  task automatic test_back_to_back();
    int s0;
    bus.CH_IN = 64'h0100_0200_0300_0400;
    exp_q.push_back(32'h1400_1400);
    s0 = samples;
    bus.CEN = 1'b1;
    @(posedge clk); #1;
    bus.CEN = 1'b0;
    @(posedge clk); #1;
    bus.CEN   = 1'b1;
    bus.CH_IN = {4{16'h7FFF}};
    @(posedge clk); #1;
    bus.CEN = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (samples - s0 != 1) begin failures++; $display("FAIL back_to_back_count got=%0d required=1", samples - s0); end
  endtask

  task automatic test_reset_mid_mix();
    int s0, lat, busy_n;
    bus.CH_IN = 64'h0100_0200_0300_0400;
    bus.CEN = 1'b1;
    @(posedge clk); #1;
    bus.CEN = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b required=0", bus.BUSY); end
    checks++; if (bus.LEFT !== 16'h0) begin failures++; $display("FAIL abort_left got=%h required=0000", bus.LEFT); end
    checks++; if (bus.RIGHT !== 16'h0) begin failures++; $display("FAIL abort_right got=%h required=0000", bus.RIGHT); end
    s0 = samples;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (samples != s0) begin failures++; $display("FAIL abort_sample got=%0d required=0", samples - s0); end
    rst_n = 1'b1;
    do_mix(1'b1, 32'h0, lat, busy_n);
    checks++; if (lat != 6) begin failures++; $display("FAIL post_reset_latency got=%0d required=6", lat); end
    settle(200);
    do_mix(1'b1, 32'h1400_1400, lat, busy_n);
    checks++; if (lat != 6) begin failures++; $display("FAIL ramped_latency got=%0d required=6", lat); end
  endtask

  task automatic test_disable_pan();
    int lat, busy_n;
    bus.CH_GAIN = {4{GAIN_UNITY}};
    bus.CH_EN   = 4'hF;
    bus.CH_IN   = 64'h0400_0300_0200_0100;
    bus.CH_PAN  = 8'b10_00_11_01;
    settle(100);
    do_mix(1'b1, 32'h0300_0600, lat, busy_n);
    bus.CH_EN = 4'b1101;
    settle(100);
    checks++; if (dut.cur_gain[1] !== 8'h00) begin failures++; $display("FAIL disabled_gain got=%h required=00", dut.cur_gain[1]); end
    do_mix(1'b1, 32'h0100_0400, lat, busy_n);
    checks++; if (lat != 6) begin failures++; $display("FAIL disabled_latency got=%0d required=6", lat); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.CEN     = 1'b0;
    bus.CH_IN   = '0;
    bus.CH_GAIN = '0;
    bus.CH_EN   = '0;
    bus.CH_PAN  = '0;
    test_reset();
    test_ramp();
    test_unity();
    test_patterns();
    test_clip();
    test_back_to_back();
    test_reset_mid_mix();
    test_disable_pan();
    settle(10);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
